tap_load_controller: RTL and testbench

//  Sequences one tap-selector fill: clears the selector, streams random bytes from the entropy

---
 rtl/tap_ctl_pkg.sv | 16 +
 rtl/tap_load_controller.sv | 130 +++++++++++++
 tb/tb_tap_load_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_ctl_pkg.sv
// Shared types and constants for the tap-selector load controller.
package tap_ctl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFill,
      StWaitDone,
      StOffer
   } tap_ctl_state_e;

   localparam int unsigned TAP_W    = 8;
   localparam logic [2:0]  POW_MASK = 3'b111;
   localparam logic [2:0]  MAX_POW  = 3'd7;

endpackage

// File: rtl/tap_load_controller.sv
// Sequences one tap-selector fill (clear, stream entropy bytes, wait done) and offers the
// captured tap vector over valid/ready. Optional byte watchdog: `define TAPCTL_WATCHDOG_EN.
module tap_load_controller
   import tap_ctl_pkg::*;
#(
   parameter int unsigned NUM_OF_TAPS = 15,
   parameter int unsigned MAX_BYTES   = 255
) (
   input  logic                           clk,
   input  logic                           res,
   input  logic                           start,
   input  logic                           rnd_valid,
   input  logic [7:0]                     rnd_data,
   output logic                           rnd_ready,
   output logic                           sel_res,
   output logic                           sel_ena,
   output logic                           sel_take,
   output logic [7:0]                     sel_din,
   input  logic                           sel_done,
   input  logic [NUM_OF_TAPS*TAP_W-1:0]   sel_taps,
   output logic                           cfg_valid,
   input  logic                           cfg_ready,
   output logic [NUM_OF_TAPS*TAP_W-1:0]   cfg_taps,
   output logic                           busy,
   output logic                           error
);

   localparam int unsigned    CntW    = $clog2(NUM_OF_TAPS + 1);
   localparam int unsigned    VecW    = NUM_OF_TAPS * TAP_W;
   localparam logic [CntW-1:0] TapMax  = CntW'(NUM_OF_TAPS);
   localparam logic [CntW-1:0] TapLast = CntW'(NUM_OF_TAPS - 1);

   if (NUM_OF_TAPS < 1 || MAX_BYTES < 1 || MAX_BYTES > 255) begin : g_param_chk
      $error("tap_load_controller: NUM_OF_TAPS or MAX_BYTES out of range");
   end

   tap_ctl_state_e  state_q, state_d;
   logic [CntW-1:0] tap_cnt_q, tap_cnt_d;
   logic [VecW-1:0] cfg_taps_q, cfg_taps_d;

   logic in_fill, hs, tap_hit, last_tap, abort;

   assign in_fill  = (state_q == StFill);
   assign hs       = in_fill && rnd_valid;
   // Zero-power bytes are consumed but never counted as taps.
   assign tap_hit  = hs && ((rnd_data[2:0] & POW_MASK) != 3'd0);
   assign last_tap = tap_hit && (tap_cnt_q == TapLast);

`ifdef TAPCTL_WATCHDOG_EN
   logic [7:0] byte_cnt_q, byte_cnt_d;

   // Abort on the handshake that consumes the MAX_BYTES-th byte unless it completes the fill.
   assign abort = hs && (byte_cnt_q == 8'(MAX_BYTES - 1)) && !last_tap;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (state_q == StClear) begin
         byte_cnt_d = '0;
      end else if (hs && byte_cnt_q != 8'hff) begin
         byte_cnt_d = byte_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         byte_cnt_q <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tap_cnt_d  = tap_cnt_q;
      cfg_taps_d = cfg_taps_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         StClear: begin
            tap_cnt_d = '0;
            state_d   = StFill;
         end
         StFill: begin
            if (tap_hit && tap_cnt_q != TapMax) tap_cnt_d = tap_cnt_q + 1'b1;
            if (last_tap) begin
               state_d = StWaitDone;
            end else if (abort) begin
               state_d = StIdle;
            end
         end
         StWaitDone: begin
            if (sel_done) begin
               cfg_taps_d = sel_taps;
               state_d    = StOffer;
            end
         end
         StOffer: begin
            if (cfg_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= StIdle;
         tap_cnt_q  <= '0;
         cfg_taps_q <= '0;
      end else begin
         state_q    <= state_d;
         tap_cnt_q  <= tap_cnt_d;
         cfg_taps_q <= cfg_taps_d;
      end
   end

   assign rnd_ready = in_fill;
   assign sel_ena   = in_fill || (state_q == StWaitDone);
   assign sel_take  = hs;
   assign sel_din   = in_fill ? rnd_data : 8'h00;
   assign sel_res   = (state_q == StClear) || abort;
   assign cfg_valid = (state_q == StOffer);
   assign cfg_taps  = cfg_taps_q;
   assign busy      = (state_q != StIdle);
   assign error     = abort;

endmodule

// File: tb/tb_tap_load_controller.sv
// Self-checking bench for tap_load_controller with a behavioural tap-selector model.
module tb_tap_load_controller;

   localparam int unsigned N  = 4;
   localparam int unsigned MB = 10;
   localparam int unsigned VW = N * 8;

   logic          clk = 1'b0;
   logic          res, start, rnd_valid, cfg_ready;
   logic [7:0]    rnd_data;
   logic          rnd_ready, sel_res, sel_ena, sel_take, sel_done, cfg_valid, busy, error;
   logic [7:0]    sel_din;
   logic [VW-1:0] sel_taps, cfg_taps;

   int n_cmp = 0;
   int n_err = 0;
   int take_cnt = 0;

   always #5 clk = ~clk;

   tap_load_controller #(
      .NUM_OF_TAPS (N),
      .MAX_BYTES   (MB)
   ) u_dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
      .rnd_ready (rnd_ready),
      .sel_res   (sel_res),
      .sel_ena   (sel_ena),
      .sel_take  (sel_take),
      .sel_din   (sel_din),
      .sel_done  (sel_done),
      .sel_taps  (sel_taps),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_taps  (cfg_taps),
      .busy      (busy),
      .error     (error)
   );

   // Selector model: stores non-zero-power bytes, raises done 2 cycles after the last take.
   int   sel_cnt;
   logic pend;
   always @(posedge clk or posedge res) begin
      if (res || sel_res) begin
         sel_cnt  <= 0;
         sel_taps <= '0;
         pend     <= 1'b0;
         sel_done <= 1'b0;
      end else begin
         sel_done <= sel_done | pend;
         pend     <= 1'b0;
         if (sel_ena && sel_take && sel_din[2:0] != 3'd0 && sel_cnt < N) begin
            sel_taps[sel_cnt*8 +: 8] <= sel_din;
            sel_cnt <= sel_cnt + 1;
            if (sel_cnt == N - 1) pend <= 1'b1;
         end
      end
   end

   always @(posedge clk) if (sel_take) take_cnt <= take_cnt + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the first N bytes whose low three bits are non-zero, packed LSB-first.
   function automatic logic [VW-1:0] ref_taps(input logic [7:0] q[$]);
      logic [VW-1:0] v = '0;
      int k = 0;
      foreach (q[i]) begin
         if (k < N && q[i][2:0] != 3'd0) begin
            v[k*8 +: 8] = q[i];
            k++;
         end
      end
      return v;
   endfunction

   task automatic run_fill(input logic [7:0] q[$], input bit gaps, input int hold,
                           input bit start_at_ready);
      logic [VW-1:0] exp_v;
      int taps, consumed, t0, lat;
      exp_v    = ref_taps(q);
      t0       = take_cnt;
      taps     = 0;
      consumed = 0;
      check("idle_busy", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clear_sel_res", {sel_res, sel_ena, rnd_ready, busy}, 4'b1001);
      tick();
      check("fill_ready", {sel_res, rnd_ready, sel_ena}, 3'b011);
      foreach (q[i]) begin
         if (taps == N) break;
         if (gaps) begin
            rnd_valid = 1'b0;
            #1;
            check("gap_no_take", sel_take, 0);
            tick();
         end
         rnd_valid = 1'b1;
         rnd_data  = q[i];
         #1;
         check("take_din", {sel_take, sel_din}, {1'b1, q[i]});
         consumed++;
         if (q[i][2:0] != 3'd0) taps++;
         tick();
      end
      rnd_valid = 1'b0;
      #1;
      check("ready_drop", {rnd_ready, sel_ena}, 2'b01);
      check("take_count", take_cnt - t0, consumed);
      lat = 0;
      while (!cfg_valid && lat < 10) begin
         tick();
         lat++;
      end
      check("cfg_latency", lat, 2);
      check("cfg_taps", cfg_taps, exp_v);
      for (int h = 0; h < hold; h++) begin
         cfg_ready = 1'b0;
         start     = h[0];
         tick();
         check("offer_hold", {cfg_valid, cfg_taps}, {1'b1, exp_v});
      end
      start     = start_at_ready;
      cfg_ready = 1'b1;
      tick();
      cfg_ready = 1'b0;
      start     = 1'b0;
      #1;
      check("offer_done", {busy, cfg_valid}, 2'b00);
      tick();
      check("start_dropped", busy, 0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      int tc;
      res = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_data = 8'h00; cfg_ready = 1'b0;
      tick();
      tick();
      check("reset_outputs",
            {busy, rnd_ready, sel_res, sel_ena, sel_take, sel_din, cfg_valid, error, cfg_taps},
            '0);
      res = 1'b0;
      tick();
      check("idle_after_reset", {busy, rnd_ready, cfg_valid}, 3'b000);

      q = '{8'h01, 8'h02, 8'h07, 8'h03};
      run_fill(q, 1'b0, 0, 1'b0);
      check("t1_value", cfg_taps, 32'h03070201);

      q = '{8'h08, 8'h10, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03};
      run_fill(q, 1'b0, 0, 1'b0);
      check("t2_value", cfg_taps, 32'h03020105);

      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_fill(q, 1'b0, 20, 1'b1);

      // Reset in the middle of a fill.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      q = '{8'h01, 8'h02};
      foreach (q[i]) begin
         rnd_valid = 1'b1;
         rnd_data  = q[i];
         tick();
      end
      rnd_data = 8'h03;
      #3;
      res = 1'b1;
      #1;
      check("async_reset",
            {busy, rnd_ready, sel_res, sel_ena, sel_take, sel_din, cfg_valid, error, cfg_taps},
            '0);
      rnd_valid = 1'b0;
      tick();
      res = 1'b0;
      tick();
      check("no_offer_after_reset", cfg_valid, 0);
      q = '{8'h09, 8'h0a, 8'h0b, 8'h0c};
      run_fill(q, 1'b0, 1, 1'b0);

      q = '{8'h01, 8'h02, 8'h07, 8'h03};
      run_fill(q, 1'b1, 0, 1'b0);
      check("t6_matches_b2b", cfg_taps, 32'h03070201);

      for (int it = 0; it < 8; it++) begin
         q  = {};
         tc = 0;
         while (tc < N) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b[2:0] = 3'd0;
            if (b[2:0] != 3'd0) tc++;
            q.push_back(b);
         end
         run_fill(q, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 1'b0);
      end

      // Stream of zero-power bytes only.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
`ifdef TAPCTL_WATCHDOG_EN
      for (int i = 1; i <= MB; i++) begin
         rnd_valid = 1'b1;
         rnd_data  = 8'h00;
         #1;
         if (i == 1) check("wd_no_early_error", error, 0);
         if (i == MB) check("wd_abort", {error, sel_res}, 2'b11);
         tick();
      end
      rnd_valid = 1'b0;
      #1;
      check("wd_idle", {busy, cfg_valid, error}, 3'b000);
      tick();
      tick();
      tick();
      check("wd_no_offer", cfg_valid, 0);
`else
      for (int i = 0; i < 300; i++) begin
         rnd_valid = 1'b1;
         rnd_data  = 8'h00;
         tick();
      end
      #1;
      check("no_wd_still_fill", {busy, rnd_ready, error, cfg_valid}, 4'b1100);
      rnd_valid = 1'b0;
      res       = 1'b1;
      tick();
      res = 1'b0;
      tick();
      check("no_wd_reset_idle", busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
